// File: rtl/apb_fifo_master_if.sv
// apb_fifo_master_if: APB4 bus bundle between the apb_fifo_master requester
// and an APB responder. The master modport drives the request side and the
// slave modport drives the completion side.
interface apb_fifo_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [2:0]              pprot;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  modport master (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_fifo_master.sv
// apb_fifo_master: APB4 requester. It takes one command from a valid/ready
// stream, runs a single APB transfer (SETUP then ACCESS), and presents the
// result on a valid/ready response stream. Only one transfer is in flight.
// All APB and response outputs come straight from flops.
// Optional build macro APB_TIMEOUT_EN: bounds the ACCESS phase to
// TIMEOUT_CYCLES cycles and reports an expired bound as rsp_err.
module apb_fifo_master #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          ADDR_WIDTH     = 32,
  parameter logic [2:0]  PPROT_VAL      = 3'b000,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy,
  apb_fifo_master_if.master       apb
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [DATA_WIDTH/8-1:0] pstrb_q, pstrb_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    busy_q, busy_d;
  logic                    cmd_ready_q, cmd_ready_d;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
`endif

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          pstrb_d  = cmd_write ? cmd_strb : '0;
          psel_d   = 1'b1;
          state_d  = ST_SETUP;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
        to_cnt_d  = '0;
`endif
      end
      ST_ACCESS: begin
        if (apb.pready) begin
          // Error is qualified by the full completion condition.
          rsp_rdata_d = pwrite_q ? '0 : apb.prdata;
          rsp_err_d   = apb.pslverr & psel_q & penable_q;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
`ifdef APB_TIMEOUT_EN
        end else if (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // This is the TIMEOUT_CYCLES-th ACCESS cycle without pready.
          to_cnt_d    = CNT_W'(TIMEOUT_CYCLES);
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          to_cnt_d    = to_cnt_q + CNT_W'(1);
          state_d     = ST_ACCESS;
        end
`else
        end else begin
          state_d     = ST_ACCESS;
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_RESP;
        end
      end
      default: begin
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
    busy_d      = (state_d != ST_IDLE);
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; presetn aborts any transfer at once.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= ST_IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  // ACCESS-phase wait counter for the timeout bound.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`endif

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = busy_q;
  assign apb.paddr   = paddr_q;
  assign apb.pprot   = PPROT_VAL;
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.pwdata  = pwdata_q;
  assign apb.pstrb   = pstrb_q;

endmodule

// File: tb/tb_apb_fifo_master.sv
// tb_apb_fifo_master: directed bench for apb_fifo_master. Inputs are driven
// and outputs sampled on the falling clock edge; the bench plays the APB
// responder itself with per-transfer wait states, read data and error.
module tb_apb_fifo_master;
  logic        pclk = 1'b0;
  logic        presetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  apb_fifo_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  apb_fifo_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .PPROT_VAL(3'b000), .TIMEOUT_CYCLES(8)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy), .apb(bus)
  );

  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge pclk);
  endtask

  // One complete transfer from IDLE up to the RESP cycle, checked cycle by cycle.
  task automatic xfer(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, input int waits,
                      input logic [31:0] rd, input logic err);
    logic [3:0] exp_strb;
    exp_strb = w ? s : 4'h0;
    check_eq({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    bus.pready = 1'b0; bus.pslverr = 1'b0;
    cyc();                                   // SETUP (T+1)
    cmd_valid = 1'b0;
    check_eq({tag, "_setup_psel"}, bus.psel, 1'b1);
    check_eq({tag, "_setup_pen"}, bus.penable, 1'b0);
    check_eq({tag, "_paddr"}, bus.paddr, a);
    check_eq({tag, "_pwrite"}, bus.pwrite, w);
    check_eq({tag, "_pwdata"}, bus.pwdata, d);
    check_eq({tag, "_pstrb"}, bus.pstrb, exp_strb);
    check_eq({tag, "_busy"}, busy, 1'b1);
    check_eq({tag, "_ready_lo"}, cmd_ready, 1'b0);
    for (int i = 0; i <= waits; i++) begin
      cyc();                                 // ACCESS (T+2+i)
      check_eq({tag, "_acc_psel"}, bus.psel, 1'b1);
      check_eq({tag, "_acc_pen"}, bus.penable, 1'b1);
      check_eq({tag, "_acc_paddr"}, bus.paddr, a);
      check_eq({tag, "_acc_pstrb"}, bus.pstrb, exp_strb);
      check_eq({tag, "_acc_rspv"}, rsp_valid, 1'b0);
      if (i == waits) begin
        bus.pready = 1'b1; bus.prdata = rd; bus.pslverr = err;
      end else begin
        bus.pready = 1'b0; bus.prdata = ~rd; bus.pslverr = ~err;
      end
    end
    cyc();                                   // RESP (T+3+waits)
    bus.pready = 1'b0; bus.pslverr = 1'b0;
    check_eq({tag, "_rspv"}, rsp_valid, 1'b1);
    check_eq({tag, "_rerr"}, rsp_err, err);
    check_eq({tag, "_rdata"}, rsp_rdata, w ? 32'h0 : rd);
    check_eq({tag, "_rsp_psel"}, bus.psel, 1'b0);
    check_eq({tag, "_rsp_pen"}, bus.penable, 1'b0);
    check_eq({tag, "_hold_paddr"}, bus.paddr, a);
    check_eq({tag, "_hold_pwdata"}, bus.pwdata, d);
  endtask

  // Cycle after a response handshake: back in IDLE.
  task automatic idle_chk(input string tag);
    cyc();
    check_eq({tag, "_idle_rspv"}, rsp_valid, 1'b0);
    check_eq({tag, "_idle_ready"}, cmd_ready, 1'b1);
    check_eq({tag, "_idle_busy"}, busy, 1'b0);
    check_eq({tag, "_idle_psel"}, bus.psel, 1'b0);
  endtask

  initial begin
    presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
    cmd_wdata = 32'h0; cmd_strb = 4'h0; rsp_ready = 1'b1;
    bus.pready = 1'b0; bus.prdata = 32'h0; bus.pslverr = 1'b0;
    cyc(); cyc();
    check_eq("rst_psel", bus.psel, 1'b0);
    check_eq("rst_pen", bus.penable, 1'b0);
    check_eq("rst_pwrite", bus.pwrite, 1'b0);
    check_eq("rst_paddr", bus.paddr, 32'h0);
    check_eq("rst_pwdata", bus.pwdata, 32'h0);
    check_eq("rst_pstrb", bus.pstrb, 4'h0);
    check_eq("rst_rspv", rsp_valid, 1'b0);
    check_eq("rst_rdata", rsp_rdata, 32'h0);
    check_eq("rst_rerr", rsp_err, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_pprot", bus.pprot, 3'b000);
    presetn = 1'b1;
    cyc();

    // Zero-wait write.
    xfer("wr08", 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 0, 32'hFFFF_FFFF, 1'b0);
    check_eq("wr08_pprot", bus.pprot, 3'b000);
    idle_chk("wr08");

    // Read with three wait states.
    xfer("rd10", 1'b0, 32'h0000_0010, 32'h0, 4'hF, 3, 32'h1234_5678, 1'b0);
    idle_chk("rd10");

    // Responder error, then a clean read.
    xfer("rd40", 1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1'b1);
    idle_chk("rd40");
    xfer("rd44", 1'b0, 32'h0000_0044, 32'h0, 4'h0, 1, 32'h0BAD_C0DE, 1'b0);
    idle_chk("rd44");

    // Response stall with a second command pending.
    rsp_ready = 1'b0;
    xfer("rd20", 1'b0, 32'h0000_0020, 32'h0, 4'h0, 0, 32'h5555_AAAA, 1'b0);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30;
    cmd_wdata = 32'hA5A5_0F0F; cmd_strb = 4'h5;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check_eq("stall_ready", cmd_ready, 1'b0);
      check_eq("stall_psel", bus.psel, 1'b0);
      check_eq("stall_rspv", rsp_valid, 1'b1);
      check_eq("stall_rdata", rsp_rdata, 32'h5555_AAAA);
    end
    rsp_ready = 1'b1;
    cyc();                                   // handshake cycle is over: IDLE
    check_eq("hs_psel", bus.psel, 1'b0);
    check_eq("hs_rspv", rsp_valid, 1'b0);
    xfer("wr30", 1'b1, 32'h0000_0030, 32'hA5A5_0F0F, 4'h5, 0, 32'h0, 1'b0);
    idle_chk("wr30");

    // Reset in the middle of ACCESS.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50;
    bus.pready = 1'b0;
    cyc();
    cmd_valid = 1'b0;
    cyc();
    check_eq("arst_pre_pen", bus.penable, 1'b1);
    #1 presetn = 1'b0;
    #1;
    check_eq("arst_psel", bus.psel, 1'b0);
    check_eq("arst_pen", bus.penable, 1'b0);
    check_eq("arst_rspv", rsp_valid, 1'b0);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_paddr", bus.paddr, 32'h0);
    cyc();
    presetn = 1'b1;
    cyc();
    xfer("rd54", 1'b0, 32'h0000_0054, 32'h0, 4'h0, 0, 32'h7777_1111, 1'b0);
    idle_chk("rd54");

`ifdef APB_TIMEOUT_EN
    // Responder never ready: eight ACCESS cycles then an error response.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h60;
    bus.pready = 1'b0; bus.prdata = 32'hAAAA_5555;
    cyc();
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check_eq("to_acc_psel", bus.psel, 1'b1);
      check_eq("to_acc_pen", bus.penable, 1'b1);
    end
    cyc();
    check_eq("to_psel", bus.psel, 1'b0);
    check_eq("to_rspv", rsp_valid, 1'b1);
    check_eq("to_rerr", rsp_err, 1'b1);
    check_eq("to_rdata", rsp_rdata, 32'h0);
    idle_chk("to");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_fifo_master.md
Name: apb_fifo_master

Overview:
- APB4 requester that drains a command stream, issues one APB transfer per command and returns a response stream.
- Sits on the host/processor side and drives APB responders such as the team's FIFO-mapped peripherals.
- One transfer is in flight at a time. All APB outputs are registered.

Parameters:
- DATA_WIDTH, 32, APB data width; multiple of 8.
- ADDR_WIDTH, 32, width of paddr and cmd_addr.
- PPROT_VAL, 3'b000, constant driven on pprot.
- TIMEOUT_CYCLES, 64, maximum ACCESS-phase cycles; used only with APB_TIMEOUT_EN.

Ports:
- pclk  in  1  clock
- presetn  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command available
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  DATA_WIDTH/8  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when high together with rsp_valid
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_err  out  1  captured pslverr, or timeout
- busy  out  1  state != IDLE
- paddr  out  ADDR_WIDTH  APB address
- pprot  out  3  APB protection, = PPROT_VAL
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DATA_WIDTH  APB write data
- pstrb  out  DATA_WIDTH/8  APB strobes
- pready  in  1  responder ready
- prdata  in  DATA_WIDTH  responder read data
- pslverr  in  1  responder error

Behaviour:
- Reset values: psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err, busy all 0; state = IDLE.
- An asserted presetn aborts any transfer immediately; a pending response is discarded.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1; cmd_ready is 0 in every other state.
  - On cmd_valid: latch paddr <= cmd_addr, pwrite <= cmd_write, pwdata <= cmd_wdata.
  - pstrb <= cmd_strb for writes; pstrb <= 0 for reads.
  - Set psel = 1 and go to SETUP.
- SETUP (exactly 1 cycle): psel = 1, penable = 0; next state ACCESS with penable = 1.
- ACCESS:
  - Hold paddr/pwrite/pwdata/pstrb/psel/penable stable until pready is sampled high.
  - On pready: rsp_rdata <= pwrite ? 0 : prdata; rsp_err <= pslverr; psel = 0, penable = 0; rsp_valid = 1; go to RESP.
- RESP:
  - Hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready.
  - On handshake: rsp_valid = 0, go to IDLE.
  - A new command is not accepted in the handshake cycle.
- Latency:
  - Command accepted at edge T; SETUP in T+1; ACCESS from T+2.
  - With pready in the first ACCESS cycle, rsp_valid is high in T+3.
  - Each wait state adds 1 cycle.
- After a transfer, paddr/pwdata/pwrite keep their last values; only psel and penable return to 0.
- pprot = PPROT_VAL whenever psel = 1.
- pslverr is ignored unless psel, penable and pready are all high.
- Response stall: while rsp_ready is low, cmd_ready stays 0. There is no command loss and no reordering.
- Maximum throughput: one transfer per 4 cycles (IDLE, SETUP, ACCESS, RESP), given zero wait states and rsp_ready held high.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- With the macro:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle without pready.
  - When the count reaches TIMEOUT_CYCLES with pready still low: drop psel/penable, set rsp_err = 1, rsp_rdata = 0, go to RESP.
  - pready in the same cycle takes priority and gives a normal completion.
- Without the macro: no counter exists and ACCESS waits indefinitely for pready.

Test Plan:
- Write addr 0x08, data 0xDEADBEEF, strb 4'hF; zero-wait responder -> psel in T+1, penable in T+2, rsp_valid in T+3 with rsp_err = 0, rsp_rdata = 0; responder sees the exact address, data and strobes.
- Read addr 0x10; responder returns 0x12345678 after 3 wait states -> paddr stable for the 4 ACCESS cycles, pstrb = 0, rsp_rdata = 0x12345678, rsp_valid in T+6.
- Read addr 0x40 with pslverr = 1 at pready -> rsp_err = 1, followed by a normal read -> rsp_err = 0.
- rsp_ready held low 10 cycles with a second cmd_valid pending -> cmd_ready = 0 and psel = 0 throughout; second command is issued only after the response handshake.
- presetn pulsed low in ACCESS -> psel, penable and rsp_valid are 0 immediately; the next command after release completes normally.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, pready stuck at 0 -> psel drops after 8 ACCESS cycles, rsp_err = 1, rsp_rdata = 0.
